// File: rtl/regs_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port between
// NUM_REQ writeback requesters. The winning command is registered before it
// reaches the register file, writes to register 0 are accepted but dropped,
// and a saturating counter records cycles with two or more pending writers.
module regs_wb_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        arb_en,
    input  logic [NUM_REQ-1:0]          req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]   req_data,
    output logic [NUM_REQ-1:0]          req_ready,
    output logic                        wr_en,
    output logic [ADDR_W-1:0]           wr_addr,
    output logic [DATA_W-1:0]           wr_data,
    input  logic                        cnt_clr,
    output logic [CNT_W-1:0]            conflict_cnt
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  ptr_next;
    logic              grant_any;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic              contention;

    // Grant the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
    always_comb begin
        int idx;
        idx       = 0;
        req_ready = '0;
        grant_any = 1'b0;
        sel_addr  = '0;
        sel_data  = '0;
        ptr_next  = rr_ptr;
        if (arb_en) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = int'(rr_ptr) + k;
                if (idx >= NUM_REQ) begin
                    idx = idx - NUM_REQ;
                end
                if (!grant_any && req_valid[idx]) begin
                    grant_any      = 1'b1;
                    req_ready[idx] = 1'b1;
                    sel_addr       = req_addr[idx*ADDR_W +: ADDR_W];
                    sel_data       = req_data[idx*DATA_W +: DATA_W];
                    ptr_next       = (idx == NUM_REQ - 1) ? '0 : PTR_W'(idx + 1);
                end
            end
        end
    end

    // Contention is only counted while arbitration is enabled.
    always_comb begin
        contention = arb_en && ($countones(req_valid) > 1);
    end

    // Round-robin pointer moves past the winner; holds when nothing is granted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= '0;
        end else begin
            rr_ptr <= ptr_next;
        end
    end

    // Registered write command; a write to register 0 is consumed but never enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_data <= '0;
        end else if (grant_any) begin
            wr_en   <= (sel_addr != '0);
            wr_addr <= sel_addr;
            wr_data <= sel_data;
        end else begin
            wr_en   <= 1'b0;
        end
    end

    // Saturating contention counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
        end else if (cnt_clr) begin
            conflict_cnt <= '0;
        end else if (contention && (conflict_cnt != {CNT_W{1'b1}})) begin
            conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_regs_wb_arbiter.sv
// Bench for regs_wb_arbiter with three requesters and a 4-bit counter:
// directed vector table, saturation and reset sequences, then randomized
// traffic compared against a behavioural model.
module tb_regs_wb_arbiter;

    localparam int N  = 3;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          arb_en;
    logic [N-1:0]  req_valid;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]  req_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          cnt_clr;
    logic [CW-1:0] conflict_cnt;

    int checks = 0;
    int errors = 0;

    regs_wb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .arb_en       (arb_en),
        .req_valid    (req_valid),
        .req_addr     (req_addr),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .cnt_clr      (cnt_clr),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        clr;
        logic [2:0]  valid;
        logic [4:0]  a0, a1, a2;
        logic [31:0] d0, d1, d2;
        logic [2:0]  exp_ready;
        logic        exp_wen;
        logic [4:0]  exp_addr;
        logic [31:0] exp_data;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs from posedge+1, sample grant at negedge,
    // then return at posedge+1 with registered outputs settled.
    task automatic run_cycle(input logic en, input logic clr, input logic [2:0] v,
                             input logic [14:0] ab, input logic [95:0] db,
                             output logic [2:0] rdy);
        arb_en    = en;
        cnt_clr   = clr;
        req_valid = v;
        req_addr  = ab;
        req_data  = db;
        @(negedge clk);
        rdy = req_ready;
        @(posedge clk);
        #1;
    endtask

    // Behavioural model state for the random phase.
    int          ptr_m;
    logic        wen_m;
    logic [4:0]  addr_m;
    logic [31:0] data_m;
    int          cnt_m;
    logic [2:0]  pend;
    logic [4:0]  pa[3];
    logic [31:0] pd[3];

    initial begin
        logic [2:0] rdy;
        rst_n     = 1'b0;
        arb_en    = 1'b0;
        cnt_clr   = 1'b0;
        req_valid = '0;
        req_addr  = '0;
        req_data  = '0;
        #12 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("reset_wen",  {31'b0, wr_en}, 32'd0);
        check("reset_addr", {27'b0, wr_addr}, 32'd0);
        check("reset_data", wr_data, 32'd0);
        check("reset_cnt",  {28'b0, conflict_cnt}, 32'd0);

        // en clr valid a0 a1 a2 d0 d1 d2 | ready wen addr data cnt
        vecs.push_back('{1,0,3'b001, 3, 0, 0,32'hDEADBEEF,0,0,        3'b001,1, 3,32'hDEADBEEF,0});
        vecs.push_back('{1,0,3'b000, 0, 0, 0,0,0,0,                   3'b000,0, 3,32'hDEADBEEF,0});
        vecs.push_back('{1,0,3'b100, 0, 0, 7,0,0,32'h77,              3'b100,1, 7,32'h77,0});
        vecs.push_back('{1,0,3'b000, 0, 0, 0,0,0,0,                   3'b000,0, 7,32'h77,0});
        vecs.push_back('{1,0,3'b011, 1, 8, 0,32'h11,32'h88,0,         3'b001,1, 1,32'h11,1});
        vecs.push_back('{1,0,3'b011, 2, 8, 0,32'h22,32'h88,0,         3'b010,1, 8,32'h88,2});
        vecs.push_back('{1,0,3'b011, 2, 9, 0,32'h22,32'h99,0,         3'b001,1, 2,32'h22,3});
        vecs.push_back('{1,0,3'b010, 0, 9, 0,0,32'h99,0,              3'b010,1, 9,32'h99,3});
        vecs.push_back('{1,0,3'b000, 0, 0, 0,0,0,0,                   3'b000,0, 9,32'h99,3});
        vecs.push_back('{1,0,3'b010, 0, 0, 0,0,32'h1234,0,            3'b010,0, 0,32'h1234,3});
        vecs.push_back('{1,0,3'b111, 4, 5, 6,32'h40,32'h50,32'h60,    3'b100,1, 6,32'h60,4});
        vecs.push_back('{1,0,3'b011, 4, 5, 0,32'h40,32'h50,0,         3'b001,1, 4,32'h40,5});
        vecs.push_back('{1,0,3'b010, 0, 5, 0,0,32'h50,0,              3'b010,1, 5,32'h50,5});
        vecs.push_back('{0,0,3'b001,10, 0, 0,32'hA0,0,0,              3'b000,0, 5,32'h50,5});
        vecs.push_back('{0,0,3'b001,10, 0, 0,32'hA0,0,0,              3'b000,0, 5,32'h50,5});
        vecs.push_back('{0,0,3'b101,10, 0,11,32'hA0,0,32'hB0,         3'b000,0, 5,32'h50,5});
        vecs.push_back('{1,0,3'b101,10, 0,11,32'hA0,0,32'hB0,         3'b100,1,11,32'hB0,6});
        vecs.push_back('{1,0,3'b001,10, 0, 0,32'hA0,0,0,              3'b001,1,10,32'hA0,6});
        vecs.push_back('{1,0,3'b000, 0, 0, 0,0,0,0,                   3'b000,0,10,32'hA0,6});
        vecs.push_back('{1,1,3'b011,12,13, 0,32'hC0,32'hD0,0,         3'b010,1,13,32'hD0,0});
        vecs.push_back('{1,0,3'b001,12, 0, 0,32'hC0,0,0,              3'b001,1,12,32'hC0,0});

        foreach (vecs[i]) begin
            run_cycle(vecs[i].en, vecs[i].clr, vecs[i].valid,
                      {vecs[i].a2, vecs[i].a1, vecs[i].a0},
                      {vecs[i].d2, vecs[i].d1, vecs[i].d0}, rdy);
            check($sformatf("vec%0d_ready", i), {29'b0, rdy}, {29'b0, vecs[i].exp_ready});
            check($sformatf("vec%0d_wen", i),  {31'b0, wr_en}, {31'b0, vecs[i].exp_wen});
            check($sformatf("vec%0d_addr", i), {27'b0, wr_addr}, {27'b0, vecs[i].exp_addr});
            check($sformatf("vec%0d_data", i), wr_data, vecs[i].exp_data);
            check($sformatf("vec%0d_cnt", i),  {28'b0, conflict_cnt}, {28'b0, vecs[i].exp_cnt});
        end

        // Counter saturation: 20 contention cycles from zero.
        for (int k = 1; k <= 20; k++) begin
            run_cycle(1'b1, 1'b0, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, rdy);
            check($sformatf("sat_cnt%0d", k), {28'b0, conflict_cnt}, (k > 15) ? 32'd15 : 32'(k));
        end
        run_cycle(1'b1, 1'b1, 3'b111, {5'd3, 5'd2, 5'd1}, {32'h3, 32'h2, 32'h1}, rdy);
        check("sat_clr", {28'b0, conflict_cnt}, 32'd0);

        // Asynchronous reset in the middle of a write.
        run_cycle(1'b1, 1'b0, 3'b001, {5'd0, 5'd0, 5'd5}, {32'h0, 32'h0, 32'h55}, rdy);
        check("t1_pre_wen",  {31'b0, wr_en}, 32'd1);
        check("t1_pre_addr", {27'b0, wr_addr}, 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check("t1_async_wen",  {31'b0, wr_en}, 32'd0);
        check("t1_async_addr", {27'b0, wr_addr}, 32'd0);
        check("t1_async_data", wr_data, 32'd0);
        check("t1_async_cnt",  {28'b0, conflict_cnt}, 32'd0);
        @(posedge clk);
        #1;
        check("t1_hold_wen", {31'b0, wr_en}, 32'd0);
        req_valid = '0;
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("t1_post_wen",  {31'b0, wr_en}, 32'd0);
        check("t1_post_data", wr_data, 32'd0);

        // Randomized traffic against the behavioural model (state after reset).
        ptr_m  = 0;
        wen_m  = 1'b0;
        addr_m = '0;
        data_m = '0;
        cnt_m  = 0;
        pend   = '0;
        for (int i = 0; i < 3; i++) begin
            pa[i] = '0;
            pd[i] = '0;
        end
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic       en;
            logic       clr;
            int         g;
            int         nvalid;
            logic [2:0] exp_rdy;
            for (int i = 0; i < 3; i++) begin
                if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                    pend[i] = 1'b1;
                    pa[i]   = 5'($urandom_range(0, 31));
                    pd[i]   = $urandom;
                end
            end
            en  = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            g = -1;
            if (en) begin
                for (int k = 0; k < 3; k++) begin
                    int i;
                    i = (ptr_m + k) % 3;
                    if (g < 0 && pend[i]) g = i;
                end
            end
            exp_rdy = (g >= 0) ? 3'(1 << g) : 3'b000;
            nvalid  = $countones(pend);
            run_cycle(en, clr, pend, {pa[2], pa[1], pa[0]}, {pd[2], pd[1], pd[0]}, rdy);
            check($sformatf("rnd%0d_ready", cyc), {29'b0, rdy}, {29'b0, exp_rdy});
            if (g >= 0) begin
                wen_m   = (pa[g] != 0);
                addr_m  = pa[g];
                data_m  = pd[g];
                ptr_m   = (g + 1) % 3;
                pend[g] = 1'b0;
            end else begin
                wen_m = 1'b0;
            end
            if (clr) cnt_m = 0;
            else if (en && nvalid >= 2 && cnt_m < 15) cnt_m++;
            check($sformatf("rnd%0d_wen", cyc),  {31'b0, wr_en}, {31'b0, wen_m});
            check($sformatf("rnd%0d_addr", cyc), {27'b0, wr_addr}, {27'b0, addr_m});
            check($sformatf("rnd%0d_data", cyc), wr_data, data_m);
            check($sformatf("rnd%0d_cnt", cyc),  {28'b0, conflict_cnt}, 32'(cnt_m));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
